store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 18 +
 rtl/store_buf_fifo.sv | 48 ++++
 rtl/store_buffer.sv | 169 ++++++++++++++++
 tb/tb_store_buffer.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: FSM encoding,
// AXI burst/response codes and prefetch depth.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam logic [2:0] FIFO_DEPTH  = 3'd2;

endpackage

// File: rtl/store_buf_fifo.sv
// Two-entry 32-bit prefetch FIFO between SRAM read data and the AXI W channel.
module store_buf_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store engine: streams SRAM words out as one AXI INCR write burst,
// prefetching through a 2-entry FIFO and reporting the B response.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_store_vld,
    output logic        ctrl_store_rdy,
    input  logic [7:0]  ctrl_store_id,
    input  logic [11:0] ctrl_store_dram_addr,
    input  logic [7:0]  ctrl_store_len,
    input  logic [2:0]  ctrl_store_size,
    input  logic [7:0]  ctrl_store_sram_addr,
    output logic        store_sram_vld,
    output logic [7:0]  store_sram_addr,
    input  logic [31:0] sram_store_dout,
    output logic [7:0]  store_axi_awid,
    output logic [11:0] store_axi_awaddr,
    output logic [7:0]  store_axi_awlen,
    output logic [2:0]  store_axi_awsize,
    output logic [1:0]  store_axi_awburst,
    output logic        store_axi_awvalid,
    input  logic        store_axi_awready,
    output logic [31:0] store_axi_wdata,
    output logic [3:0]  store_axi_wstrb,
    output logic        store_axi_wlast,
    output logic        store_axi_wvalid,
    input  logic        store_axi_wready,
    input  logic [7:0]  store_axi_bid,
    input  logic [1:0]  store_axi_bresp,
    input  logic        store_axi_bvalid,
    output logic        store_axi_bready,
    output logic        store_done,
    output logic        store_err
);

    state_t      state;
    state_t      next_state;

    logic [7:0]  id_q;
    logic [11:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [7:0]  rd_addr;
    logic [8:0]  rd_cnt;
    logic [8:0]  beat_cnt;
    logic [8:0]  beats_total;
    logic        inflight;

    logic        accept;
    logic        rd_en;
    logic        w_pop;
    logic [2:0]  used;

    logic [31:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_count;

    store_buf_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (w_pop),
        .din   (sram_store_dout),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign beats_total       = {1'b0, len_q} + 9'd1;
    assign accept            = ctrl_store_vld && ctrl_store_rdy;

    assign store_axi_awid    = id_q;
    assign store_axi_awaddr  = addr_q;
    assign store_axi_awlen   = len_q;
    assign store_axi_awsize  = size_q;
    assign store_axi_awburst = BURST_INCR;
    assign store_axi_wdata   = fifo_dout;
    assign store_axi_wstrb   = 4'hF;
    assign store_axi_wlast   = (beat_cnt == {1'b0, len_q});
    assign store_sram_vld    = rd_en;
    assign store_sram_addr   = rd_addr;

    // A beat leaving this cycle frees a slot for a read issued this cycle.
    assign used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, w_pop};

    always_comb begin
        next_state        = state;
        ctrl_store_rdy    = 1'b0;
        store_axi_awvalid = 1'b0;
        store_axi_wvalid  = 1'b0;
        store_axi_bready  = 1'b0;
        store_done        = 1'b0;
        store_err         = 1'b0;
        w_pop             = 1'b0;
        rd_en             = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ctrl_store_rdy = 1'b1;
                if (ctrl_store_vld) begin
                    next_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                store_axi_awvalid = 1'b1;
                if (store_axi_awready) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                store_axi_wvalid = !fifo_empty;
                w_pop = !fifo_empty && store_axi_wready;
                if (w_pop && store_axi_wlast) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                store_axi_bready = 1'b1;
                if (store_axi_bvalid) begin
                    store_done = 1'b1;
                    store_err  = (store_axi_bresp != RESP_OKAY);
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if ((state == ST_ADDR || state == ST_DATA)
            && used < FIFO_DEPTH && rd_cnt < beats_total) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            rd_addr  <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= rd_en;
            if (accept) begin
                id_q     <= ctrl_store_id;
                addr_q   <= ctrl_store_dram_addr;
                len_q    <= ctrl_store_len;
                size_q   <= ctrl_store_size;
                rd_addr  <= ctrl_store_sram_addr;
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end
            if (rd_en) begin
                rd_cnt  <= rd_cnt + 9'd1;
                rd_addr <= rd_addr + 8'd1;
            end
            if (w_pop) begin
                beat_cnt <= beat_cnt + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: SRAM model, AXI slave responder,
// per-scenario tasks with inline checks.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_store_vld = 1'b0;
    logic        ctrl_store_rdy;
    logic [7:0]  ctrl_store_id = '0;
    logic [11:0] ctrl_store_dram_addr = '0;
    logic [7:0]  ctrl_store_len = '0;
    logic [2:0]  ctrl_store_size = '0;
    logic [7:0]  ctrl_store_sram_addr = '0;
    logic        store_sram_vld;
    logic [7:0]  store_sram_addr;
    logic [31:0] sram_store_dout = '0;
    logic [7:0]  store_axi_awid;
    logic [11:0] store_axi_awaddr;
    logic [7:0]  store_axi_awlen;
    logic [2:0]  store_axi_awsize;
    logic [1:0]  store_axi_awburst;
    logic        store_axi_awvalid;
    logic        store_axi_awready = 1'b0;
    logic [31:0] store_axi_wdata;
    logic [3:0]  store_axi_wstrb;
    logic        store_axi_wlast;
    logic        store_axi_wvalid;
    logic        store_axi_wready = 1'b0;
    logic [7:0]  store_axi_bid = 8'h00;
    logic [1:0]  store_axi_bresp = 2'b00;
    logic        store_axi_bvalid = 1'b0;
    logic        store_axi_bready;
    logic        store_done;
    logic        store_err;

    store_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .ctrl_store_vld       (ctrl_store_vld),
        .ctrl_store_rdy       (ctrl_store_rdy),
        .ctrl_store_id        (ctrl_store_id),
        .ctrl_store_dram_addr (ctrl_store_dram_addr),
        .ctrl_store_len       (ctrl_store_len),
        .ctrl_store_size      (ctrl_store_size),
        .ctrl_store_sram_addr (ctrl_store_sram_addr),
        .store_sram_vld       (store_sram_vld),
        .store_sram_addr      (store_sram_addr),
        .sram_store_dout      (sram_store_dout),
        .store_axi_awid       (store_axi_awid),
        .store_axi_awaddr     (store_axi_awaddr),
        .store_axi_awlen      (store_axi_awlen),
        .store_axi_awsize     (store_axi_awsize),
        .store_axi_awburst    (store_axi_awburst),
        .store_axi_awvalid    (store_axi_awvalid),
        .store_axi_awready    (store_axi_awready),
        .store_axi_wdata      (store_axi_wdata),
        .store_axi_wstrb      (store_axi_wstrb),
        .store_axi_wlast      (store_axi_wlast),
        .store_axi_wvalid     (store_axi_wvalid),
        .store_axi_wready     (store_axi_wready),
        .store_axi_bid        (store_axi_bid),
        .store_axi_bresp      (store_axi_bresp),
        .store_axi_bvalid     (store_axi_bvalid),
        .store_axi_bready     (store_axi_bready),
        .store_done           (store_done),
        .store_err            (store_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        logic [11:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } aw_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    int checks = 0;
    int failures = 0;

    aw_t   aw_q[$];
    beat_t beat_q[$];
    logic [7:0] rd_q[$];
    logic  err_q[$];

    int done_cnt = 0;
    int rd_total = 0;
    int beat_total = 0;

    int         aw_delay = 0;
    int         aw_wait = 0;
    logic [3:0] w_pat = 4'b1111;
    int         w_idx = 0;
    logic [1:0] bresp_cfg = 2'b00;

    logic        hold_w = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    logic        hold_aw = 1'b0;
    aw_t         hold_awp;

    function automatic logic [31:0] mem_val(input logic [7:0] a);
        return {a, ~a, 8'h3C, a ^ 8'hA5};
    endfunction

    // SRAM: one-cycle read latency, garbage when not enabled
    always @(posedge clk) begin
        sram_store_dout <= store_sram_vld ? mem_val(store_sram_addr) : 32'hDEAD_BEEF;
    end

    // AXI slave responder
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (store_axi_awvalid) begin
                store_axi_awready = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                store_axi_awready = 1'b0;
                aw_wait = 0;
            end
            store_axi_wready = w_pat[w_idx];
            w_idx = (w_idx + 1) % 4;
            store_axi_bvalid = store_axi_bready;
            store_axi_bresp  = bresp_cfg;
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        logic wpop;
        logic [7:0] ea;
        beat_t eb;
        aw_t ew;
        logic ee;
        if (rst) begin
            aw_q.delete();
            beat_q.delete();
            rd_q.delete();
            err_q.delete();
            rd_total = 0;
            beat_total = 0;
            hold_w = 1'b0;
            hold_aw = 1'b0;
        end else begin
            wpop = store_axi_wvalid && store_axi_wready;
            if (store_sram_vld) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL sram_read unexpected addr=%h", store_sram_addr);
                end else begin
                    ea = rd_q.pop_front();
                    if (store_sram_addr !== ea) begin
                        failures++;
                        $display("FAIL sram_addr got=%h exp=%h", store_sram_addr, ea);
                    end
                end
                rd_total++;
                checks++;
                if (rd_total - beat_total - (wpop ? 1 : 0) > 2) begin
                    failures++;
                    $display("FAIL fifo_overflow outstanding=%0d exp<=2",
                             rd_total - beat_total - (wpop ? 1 : 0));
                end
            end
            if (hold_w) begin
                checks++;
                if (store_axi_wvalid !== 1'b1 || store_axi_wdata !== hold_data
                    || store_axi_wlast !== hold_last) begin
                    failures++;
                    $display("FAIL w_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             store_axi_wvalid, store_axi_wdata, store_axi_wlast,
                             hold_data, hold_last);
                end
            end
            if (wpop) begin
                checks++;
                if (beat_q.size() == 0) begin
                    failures++;
                    $display("FAIL w_beat unexpected data=%h", store_axi_wdata);
                end else begin
                    eb = beat_q.pop_front();
                    if (store_axi_wdata !== eb.data || store_axi_wlast !== eb.last
                        || store_axi_wstrb !== 4'hF) begin
                        failures++;
                        $display("FAIL w_beat got d=%h l=%b s=%h exp d=%h l=%b s=f",
                                 store_axi_wdata, store_axi_wlast, store_axi_wstrb,
                                 eb.data, eb.last);
                    end
                end
                beat_total++;
            end
            hold_w    = store_axi_wvalid && !store_axi_wready;
            hold_data = store_axi_wdata;
            hold_last = store_axi_wlast;
            if (hold_aw) begin
                checks++;
                if (store_axi_awvalid !== 1'b1 || store_axi_awid !== hold_awp.id
                    || store_axi_awaddr !== hold_awp.addr || store_axi_awlen !== hold_awp.len
                    || store_axi_awsize !== hold_awp.size) begin
                    failures++;
                    $display("FAIL aw_stable got v=%b id=%h a=%h exp id=%h a=%h",
                             store_axi_awvalid, store_axi_awid, store_axi_awaddr,
                             hold_awp.id, hold_awp.addr);
                end
            end
            if (store_axi_awvalid && store_axi_awready) begin
                checks++;
                if (aw_q.size() == 0) begin
                    failures++;
                    $display("FAIL aw unexpected id=%h", store_axi_awid);
                end else begin
                    ew = aw_q.pop_front();
                    if (store_axi_awid !== ew.id || store_axi_awaddr !== ew.addr
                        || store_axi_awlen !== ew.len || store_axi_awsize !== ew.size
                        || store_axi_awburst !== 2'b01) begin
                        failures++;
                        $display("FAIL aw got id=%h a=%h l=%h s=%h b=%b exp id=%h a=%h l=%h s=%h b=01",
                                 store_axi_awid, store_axi_awaddr, store_axi_awlen,
                                 store_axi_awsize, store_axi_awburst,
                                 ew.id, ew.addr, ew.len, ew.size);
                    end
                end
            end
            hold_aw = store_axi_awvalid && !store_axi_awready;
            hold_awp.id   = store_axi_awid;
            hold_awp.addr = store_axi_awaddr;
            hold_awp.len  = store_axi_awlen;
            hold_awp.size = store_axi_awsize;
            if (store_done) begin
                done_cnt++;
                checks++;
                if (err_q.size() == 0) begin
                    failures++;
                    $display("FAIL done unexpected err=%b", store_err);
                end else begin
                    ee = err_q.pop_front();
                    if (store_err !== ee) begin
                        failures++;
                        $display("FAIL done_err got=%b exp=%b", store_err, ee);
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] id, input logic [11:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [7:0] sram, input logic exp_err);
        aw_t   w;
        beat_t b;
        logic [7:0] a;
        int c;
        c = 0;
        @(negedge clk);
        while (ctrl_store_rdy !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (ctrl_store_rdy !== 1'b1) begin
            failures++;
            $display("FAIL cmd_rdy_timeout rdy=%b exp=1", ctrl_store_rdy);
        end
        w.id = id; w.addr = addr; w.len = len; w.size = size;
        aw_q.push_back(w);
        for (int i = 0; i <= int'(len); i++) begin
            a = sram + 8'(i);
            rd_q.push_back(a);
            b.data = mem_val(a);
            b.last = (i == int'(len));
            beat_q.push_back(b);
        end
        err_q.push_back(exp_err);
        @(posedge clk);
        #1;
        ctrl_store_vld = 1'b1;
        ctrl_store_id = id;
        ctrl_store_dram_addr = addr;
        ctrl_store_len = len;
        ctrl_store_size = size;
        ctrl_store_sram_addr = sram;
        @(posedge clk);
        #1;
        ctrl_store_vld = 1'b0;
        ctrl_store_id = 8'hEE;
        ctrl_store_sram_addr = 8'hEE;
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 300 && done_cnt < target; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL done_timeout got=%0d exp=%0d", done_cnt, target);
        end
        checks++;
        if (rd_q.size() != 0 || beat_q.size() != 0 || aw_q.size() != 0 || err_q.size() != 0) begin
            failures++;
            $display("FAIL leftover rd=%0d beat=%0d aw=%0d err=%0d exp=0",
                     rd_q.size(), beat_q.size(), aw_q.size(), err_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_store_rdy !== 1'b1 || store_axi_awvalid !== 1'b0 || store_axi_wvalid !== 1'b0
            || store_sram_vld !== 1'b0 || store_axi_bready !== 1'b0
            || store_done !== 1'b0 || store_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state rdy=%b aw=%b w=%b rd=%b b=%b d=%b e=%b exp 1000000",
                     ctrl_store_rdy, store_axi_awvalid, store_axi_wvalid, store_sram_vld,
                     store_axi_bready, store_done, store_err);
        end
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        send_cmd(8'h11, 12'h400, 8'd3, 3'd2, 8'h10, 1'b0);
        wait_done(d0 + 1);
    endtask

    task automatic test_len0();
        int d0;
        d0 = done_cnt;
        send_cmd(8'h22, 12'h0FC, 8'd0, 3'd2, 8'hFF, 1'b0);
        wait_done(d0 + 1);
    endtask

    task automatic test_wrap();
        int d0;
        d0 = done_cnt;
        send_cmd(8'h33, 12'h800, 8'd2, 3'd2, 8'hFE, 1'b0);
        wait_done(d0 + 1);
    endtask

    task automatic test_stall();
        int d0;
        d0 = done_cnt;
        w_pat = 4'b1001;
        send_cmd(8'h44, 12'h123, 8'd7, 3'd2, 8'h40, 1'b0);
        wait_done(d0 + 1);
        w_pat = 4'b1111;
    endtask

    task automatic test_aw_delay();
        int d0;
        d0 = done_cnt;
        aw_delay = 5;
        bresp_cfg = 2'b10;
        send_cmd(8'h55, 12'hABC, 8'd2, 3'd1, 8'h80, 1'b1);
        wait_done(d0 + 1);
        aw_delay = 0;
        bresp_cfg = 2'b00;
    endtask

    task automatic test_ignore();
        int d0;
        d0 = done_cnt;
        w_pat = 4'b0001;
        send_cmd(8'h66, 12'h200, 8'd4, 3'd2, 8'h30, 1'b0);
        ctrl_store_vld = 1'b1;
        ctrl_store_sram_addr = 8'h99;
        ctrl_store_len = 8'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl_store_rdy !== 1'b0) begin
                failures++;
                $display("FAIL busy_rdy cycle=%0d got=%b exp=0", i, ctrl_store_rdy);
            end
        end
        @(posedge clk);
        #1;
        ctrl_store_vld = 1'b0;
        wait_done(d0 + 1);
        w_pat = 4'b1111;
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        send_cmd(8'h77, 12'h010, 8'd1, 3'd2, 8'h50, 1'b0);
        send_cmd(8'h78, 12'h020, 8'd2, 3'd2, 8'h52, 1'b0);
        wait_done(d0 + 2);
    endtask

    task automatic test_reset_mid();
        int d0;
        int c;
        d0 = done_cnt;
        send_cmd(8'h88, 12'h300, 8'd3, 3'd2, 8'h20, 1'b0);
        c = 0;
        while (beat_total < 1 && c < 50) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (beat_total < 1) begin
            failures++;
            $display("FAIL mid_beat_timeout beats=%0d exp>=1", beat_total);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_store_rdy !== 1'b1 || store_axi_wvalid !== 1'b0 || store_sram_vld !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset rdy=%b w=%b rd=%b exp 100",
                     ctrl_store_rdy, store_axi_wvalid, store_sram_vld);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL mid_reset_done got=%0d exp=%0d", done_cnt, d0);
        end
        send_cmd(8'h99, 12'h340, 8'd3, 3'd2, 8'h60, 1'b0);
        wait_done(d0 + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_stall();
        test_aw_delay();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
